// File: rtl/tc_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM state
// encodings, register offsets inside the 16-byte window, CTRL field
// positions and MODE encodings.
package tc_timer_pkg;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  // Byte offsets of the registers inside the window
  localparam logic [3:0] TC_CTRL   = 4'h0;
  localparam logic [3:0] TC_PRESET = 4'h4;
  localparam logic [3:0] TC_COUNT  = 4'h8;
  localparam logic [3:0] TC_RSVD   = 4'hC;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // MODE encodings; 2'b1x behaves as one-shot
  localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/tc_timer_if.sv
// Data-bus slice seen by the timer: M-stage address, byte enables and
// write data from the CPU, plus the combinational read data returned.
interface tc_timer_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output byteen, output wdata, input rdata);
  modport slave  (input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/tc_timer.sv
// Countdown timer with CTRL/PRESET/COUNT registers in a 16-byte window.
// One-shot or auto-reload operation; irq is the registered expiry flag
// gated by the CTRL interrupt mask. BASE_ADDR must be 16-byte aligned.
module tc_timer
  import tc_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  tc_timer_if.slave   bus,
  output logic        irq
);

  tc_state_e   state;
  tc_state_e   state_next;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        hit;
  logic        wr;
  logic [3:0]  offset;
  logic        ctrl_wr;
  logic        preset_wr;
  logic [31:0] ctrl_merged;
  logic        ctrl_en;
  logic [1:0]  mode;

  logic        load_count;
  logic        dec_count;
  logic        set_flag;
  logic        clr_flag_hw;
  logic        clr_en_hw;

  logic        unused_bits;

  // Byte-lane merge: only lanes with byteen set take the new data
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign hit         = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign wr          = hit && (bus.byteen != 4'b0000);
  assign offset      = {bus.addr[3:2], 2'b00};
  assign ctrl_wr     = wr && (offset == TC_CTRL);
  assign preset_wr   = wr && (offset == TC_PRESET);
  assign ctrl_merged = byte_merge({28'd0, ctrl}, bus.wdata, bus.byteen);
  assign ctrl_en     = ctrl[CTRL_EN_BIT];
  assign mode        = ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign irq         = irq_flag & ctrl[CTRL_IM_BIT];

  // Byte-address low bits and the unimplemented CTRL bits are don't-cares
  assign unused_bits = ^{bus.addr[1:0], ctrl_merged[31:4]};

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= TC_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and datapath strobes for COUNT, EN and the flag
  always_comb begin
    state_next  = state;
    load_count  = 1'b0;
    dec_count   = 1'b0;
    set_flag    = 1'b0;
    clr_flag_hw = 1'b0;
    clr_en_hw   = 1'b0;
    case (state)
      TC_IDLE: begin
        if (ctrl_en) state_next = TC_LOAD;
      end
      TC_LOAD: begin
        load_count = 1'b1;
        state_next = TC_CNT;
      end
      TC_CNT: begin
        if (!ctrl_en) begin
          state_next = TC_IDLE;
        end else if (count == 32'd0) begin
          state_next = TC_INT;
          set_flag   = 1'b1;
        end else begin
          dec_count = 1'b1;
        end
      end
      TC_INT: begin
        if (mode == TC_MODE_RELOAD) begin
          state_next  = TC_LOAD;
          clr_flag_hw = 1'b1;
        end else begin
          state_next = TC_IDLE;
          clr_en_hw  = 1'b1;
        end
      end
      default: state_next = TC_IDLE;
    endcase
  end

  // CTRL: a CPU write overrides the hardware EN clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         ctrl <= 4'd0;
    else if (ctrl_wr)   ctrl <= ctrl_merged[3:0];
    else if (clr_en_hw) ctrl[CTRL_EN_BIT] <= 1'b0;
  end

  // PRESET: byte-merged write, only sampled by COUNT in LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         preset <= 32'd0;
    else if (preset_wr) preset <= byte_merge(preset, bus.wdata, bus.byteen);
  end

  // COUNT: load from PRESET, decrement only while nonzero so it never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          count <= 32'd0;
    else if (load_count) count <= preset;
    else if (dec_count)  count <= count - 32'd1;
  end

  // Expiry flag: setting beats a simultaneous CTRL write clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      irq_flag <= 1'b0;
    else if (set_flag)               irq_flag <= 1'b1;
    else if (ctrl_wr || clr_flag_hw) irq_flag <= 1'b0;
  end

  // Combinational read mux; misses and the reserved word read 0
  always_comb begin
    bus.rdata = 32'd0;
    if (hit) begin
      case (offset)
        TC_CTRL:   bus.rdata = {28'd0, ctrl};
        TC_PRESET: bus.rdata = preset;
        TC_COUNT:  bus.rdata = count;
        default:   bus.rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: expected values go into a scoreboard queue
// as each step is driven and are popped when the DUT output is sampled.
module tb_tc_timer;
  import tc_timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;

  tc_timer_if bus();

  tc_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic pushExpect(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=%h", observed);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (observed === e.value) else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus write, completed at the next rising edge
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] data);
    bus.addr   = addr;
    bus.byteen = be;
    bus.wdata  = data;
    @(posedge clk);
    #1;
    bus.byteen = 4'b0000;
    bus.wdata  = 32'd0;
    bus.addr   = 32'd0;
  endtask

  task automatic writeReg(input logic [3:0] off, input logic [31:0] data);
    applyStimulus(BASE | {28'd0, off}, 4'b1111, data);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr,
                           input logic [31:0] expected);
    pushExpect(tag, expected);
    bus.addr = addr;
    #1;
    checkOutput(bus.rdata);
    bus.addr = 32'd0;
  endtask

  task automatic regCheck(input string tag, input logic [3:0] off,
                          input logic [31:0] expected);
    readCheck(tag, BASE | {28'd0, off}, expected);
  endtask

  task automatic irqCheck(input string tag, input logic expected);
    pushExpect(tag, {31'd0, expected});
    checkOutput({31'd0, irq});
  endtask

  initial begin
    bus.addr   = 32'd0;
    bus.byteen = 4'b0000;
    bus.wdata  = 32'd0;

    // Reset readback
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    regCheck("rst_ctrl", TC_CTRL, 32'd0);
    regCheck("rst_preset", TC_PRESET, 32'd0);
    regCheck("rst_count", TC_COUNT, 32'd0);
    irqCheck("rst_irq", 1'b0);

    // One-shot expiry, PRESET 3: irq rises at E6
    writeReg(TC_PRESET, 32'd3);
    writeReg(TC_CTRL, 32'h9);
    regCheck("os_count_e0", TC_COUNT, 32'd0);
    tick(2);
    regCheck("os_count_e2", TC_COUNT, 32'd3);
    tick(1);
    regCheck("os_count_e3", TC_COUNT, 32'd2);
    tick(1);
    regCheck("os_count_e4", TC_COUNT, 32'd1);
    tick(1);
    regCheck("os_count_e5", TC_COUNT, 32'd0);
    irqCheck("os_irq_e5", 1'b0);
    tick(1);
    irqCheck("os_irq_e6", 1'b1);
    tick(1);
    regCheck("os_ctrl_after", TC_CTRL, 32'h8);
    irqCheck("os_irq_held", 1'b1);
    writeReg(TC_CTRL, 32'h8);
    irqCheck("os_irq_cleared", 1'b0);

    // Auto-reload, PRESET 2: pulses at E5 and E10
    writeReg(TC_PRESET, 32'd2);
    writeReg(TC_CTRL, 32'hB);
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      irqCheck($sformatf("ar_irq_e%0d", k), (k == 5) || (k == 10));
    end
    regCheck("ar_ctrl_en_kept", TC_CTRL, 32'hB);
    writeReg(TC_CTRL, 32'h0);
    tick(1);
    irqCheck("ar_stopped_irq", 1'b0);

    // Masked expiry with PRESET 0: EN self-clears, irq stays low
    writeReg(TC_PRESET, 32'd0);
    writeReg(TC_CTRL, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      irqCheck($sformatf("mask_irq_e%0d", k), 1'b0);
      if (k == 2) regCheck("mask_count_loaded", TC_COUNT, 32'd0);
    end
    regCheck("mask_ctrl_expired", TC_CTRL, 32'h0);

    // Byte enables and ignored/reserved/miss accesses
    applyStimulus(BASE | {28'd0, TC_PRESET}, 4'b0010, 32'hAABBCCDD);
    regCheck("be_preset_lane1", TC_PRESET, 32'h0000CC00);
    applyStimulus(BASE | {28'd0, TC_PRESET}, 4'b1001, 32'h11223344);
    regCheck("be_preset_lane30", TC_PRESET, 32'h1100CC44);
    writeReg(TC_COUNT, 32'hFFFFFFFF);
    regCheck("count_write_ignored", TC_COUNT, 32'd0);
    writeReg(TC_RSVD, 32'hFFFFFFFF);
    regCheck("rsvd_reads_zero", TC_RSVD, 32'd0);
    applyStimulus(BASE + 32'h10, 4'b1111, 32'h9);
    regCheck("miss_write_ignored", TC_CTRL, 32'h0);
    readCheck("miss_reads_zero", BASE + 32'h14, 32'd0);

    // Disable and PRESET change mid-count
    writeReg(TC_PRESET, 32'd10);
    writeReg(TC_CTRL, 32'h9);
    irqCheck("dis_irq_flag_cleared", 1'b0);
    tick(6);
    regCheck("dis_count_6", TC_COUNT, 32'd6);
    writeReg(TC_PRESET, 32'd2);
    regCheck("dis_count_unaffected", TC_COUNT, 32'd5);
    regCheck("dis_preset_new", TC_PRESET, 32'd2);
    tick(1);
    regCheck("dis_count_4", TC_COUNT, 32'd4);
    writeReg(TC_CTRL, 32'h8);
    regCheck("dis_count_3", TC_COUNT, 32'd3);
    tick(1);
    regCheck("dis_frozen_a", TC_COUNT, 32'd3);
    tick(1);
    regCheck("dis_frozen_b", TC_COUNT, 32'd3);
    irqCheck("dis_no_irq", 1'b0);
    writeReg(TC_CTRL, 32'h9);
    tick(2);
    regCheck("dis_reload_2", TC_COUNT, 32'd2);
    writeReg(TC_CTRL, 32'h8);
    tick(1);
    regCheck("dis_stop_1", TC_COUNT, 32'd1);

    // Asynchronous reset between edges while COUNT is 5
    writeReg(TC_PRESET, 32'd7);
    writeReg(TC_CTRL, 32'h9);
    tick(4);
    regCheck("ar_pre_count_5", TC_COUNT, 32'd5);
    #2;
    reset = 1'b0;
    #1;
    regCheck("arst_count", TC_COUNT, 32'd0);
    regCheck("arst_ctrl", TC_CTRL, 32'd0);
    regCheck("arst_preset", TC_PRESET, 32'd0);
    irqCheck("arst_irq", 1'b0);
    tick(2);
    reset = 1'b1;
    tick(3);
    regCheck("post_rst_count", TC_COUNT, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
